// File: rtl/lfsr16_checker.sv
// Receive-side PRBS checker for the x^16+x^14+x^13+x^11+1 Fibonacci LFSR:
// seeds from the stream, verifies LOCK_CNT predictions, then counts deviations.
module lfsr16_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic [15:0]      din,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             sync_lost,
    output logic             zero_seen
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    state_t      state, state_nxt;
    logic [15:0] pred, pred_nxt;
    logic [3:0]  run, run_nxt, miss, miss_nxt;
    logic [3:0]  run_inc, miss_inc;
    logic        mis_lk, lost, zero_w;

    function automatic logic [15:0] nxt(input logic [15:0] w);
        return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
    endfunction

    assign run_inc  = run + 4'd1;
    assign miss_inc = miss + 4'd1;

    always_comb begin
        state_nxt = state;
        pred_nxt  = pred;
        run_nxt   = run;
        miss_nxt  = miss;
        mis_lk    = 1'b0;
        lost      = 1'b0;
        zero_w    = 1'b0;
        if (din_valid) begin
            if (din == 16'h0000) begin
                // The all-zero lock-up word can never seed the predictor.
                zero_w    = 1'b1;
                state_nxt = HUNT;
                run_nxt   = 4'd0;
                if (state == LOCKED) begin
                    mis_lk = 1'b1;
                    lost   = 1'b1;
                end
            end else begin
                case (state)
                    HUNT: begin
                        pred_nxt  = nxt(din);
                        run_nxt   = 4'd0;
                        state_nxt = VERIFY;
                    end
                    VERIFY: begin
                        pred_nxt = nxt(din);
                        if (din == pred) begin
                            run_nxt = run_inc;
                            if (run_inc == LOCK_C) begin
                                state_nxt = LOCKED;
                                miss_nxt  = 4'd0;
                            end
                        end else begin
                            run_nxt = 4'd0;
                        end
                    end
                    LOCKED: begin
                        // Free-running once locked so errors are not absorbed by reseeding.
                        pred_nxt = nxt(pred);
                        if (din == pred) begin
                            miss_nxt = 4'd0;
                        end else begin
                            mis_lk   = 1'b1;
                            miss_nxt = miss_inc;
                            if (miss_inc == LOSS_C) begin
                                state_nxt = HUNT;
                                lost      = 1'b1;
                            end
                        end
                    end
                    default: state_nxt = HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            pred      <= 16'hFFFF;
            run       <= 4'd0;
            miss      <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            sync_lost <= 1'b0;
            zero_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            pred      <= pred_nxt;
            run       <= run_nxt;
            miss      <= miss_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= mis_lk;
            if (clear_err) begin
                err_count <= '0;
                sync_lost <= 1'b0;
                zero_seen <= 1'b0;
            end else begin
                if (mis_lk && (err_count != {ERR_W{1'b1}}))
                    err_count <= err_count + ERR_W'(1);
                if (lost)
                    sync_lost <= 1'b1;
                if (zero_w)
                    zero_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr16_checker.sv
// Directed plus randomized bench for lfsr16_checker against a per-sample behavioural model.
module tb_lfsr16_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int ERR_W    = 4;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             din_valid = 1'b0;
    logic [15:0]      din = 16'h0;
    logic             clear_err = 1'b0;
    logic             locked, err_pulse, sync_lost, zero_seen;
    logic [ERR_W-1:0] err_count;

    always #5 clk = ~clk;

    lfsr16_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clear_err(clear_err),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .sync_lost(sync_lost), .zero_seen(zero_seen)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: "have a seed", "matches since seed", "misses while locked".
    bit          m_lock, m_seeded, m_pulse, m_sync, m_zero;
    logic [15:0] m_pred;
    int          m_run, m_miss, m_err;

    logic [15:0] g;
    int          pulses;
    int          cnt;

    function automatic logic [15:0] nxt(input logic [15:0] w);
        return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic v, input logic [15:0] d, input logic c, input logic r);
        m_pulse = 1'b0;
        if (r) begin
            m_lock = 0; m_seeded = 0; m_sync = 0; m_zero = 0;
            m_pred = 16'hFFFF; m_run = 0; m_miss = 0; m_err = 0;
            return;
        end
        if (v) begin
            if (d == 16'h0000) begin
                m_zero = 1;
                if (m_lock) begin
                    m_pulse = 1; m_sync = 1;
                    if (m_err < ERR_MAX) m_err++;
                end
                m_lock = 0; m_seeded = 0; m_run = 0;
            end else if (m_lock) begin
                if (d == m_pred) m_miss = 0;
                else begin
                    m_pulse = 1;
                    if (m_err < ERR_MAX) m_err++;
                    m_miss++;
                    if (m_miss >= LOSS_CNT) begin
                        m_lock = 0; m_seeded = 0; m_sync = 1;
                    end
                end
                m_pred = nxt(m_pred);
            end else if (!m_seeded) begin
                m_seeded = 1; m_run = 0; m_pred = nxt(d);
            end else begin
                if (d == m_pred) begin
                    m_run++;
                    if (m_run >= LOCK_CNT) begin
                        m_lock = 1; m_miss = 0;
                    end
                end else m_run = 0;
                m_pred = nxt(d);
            end
        end
        if (c) begin
            m_err = 0; m_sync = 0; m_zero = 0;
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic c = 1'b0, input logic r = 1'b0);
        reset = r; din_valid = v; din = d; clear_err = c;
        @(posedge clk);
        #1;
        model(v, d, c, r);
        check("locked",    32'(locked),    32'(m_lock));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("err_count", 32'(err_count), 32'(m_err));
        check("sync_lost", 32'(sync_lost), 32'(m_sync));
        check("zero_seen", 32'(zero_seen), 32'(m_zero));
        if (err_pulse) pulses++;
    endtask

    task automatic good();
        step(1'b1, g);
        g = nxt(g);
    endtask

    initial begin
        pulses = 0;
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("rst_locked", 32'(locked), 0);
        check("rst_errcnt", 32'(err_count), 0);
        check("rst_pulse",  32'(err_pulse), 0);

        // Lock: seed FFFF then four matches.
        g = 16'hFFFF;
        repeat (4) good();
        check("prelock", 32'(locked), 0);
        good();
        check("lock_after_fff0", 32'(locked), 1);

        repeat (1000) good();
        check("clean_errcnt", 32'(err_count), 0);
        check("clean_pulses", 32'(pulses), 0);

        // Single-bit error.
        step(1'b1, g ^ 16'h0002); g = nxt(g);
        repeat (20) good();
        check("single_pulses", 32'(pulses), 1);
        check("single_errcnt", 32'(err_count), 1);
        check("single_locked", 32'(locked), 1);
        check("single_sync",   32'(sync_lost), 0);

        // Loss of sync.
        step(1'b1, g, 1'b1); g = nxt(g);
        step(1'b1, 16'h1234); g = nxt(g);
        step(1'b1, 16'h5678); g = nxt(g);
        check("loss_still_locked", 32'(locked), 1);
        step(1'b1, 16'h9ABC); g = nxt(g);
        check("loss_errcnt", 32'(err_count), 3);
        check("loss_locked", 32'(locked), 0);
        check("loss_sync",   32'(sync_lost), 1);
        repeat (4) good();
        check("relock_pre", 32'(locked), 0);
        good();
        check("relock", 32'(locked), 1);

        // Zero word drops lock; then gapped relock takes the same sample count.
        step(1'b1, 16'h0000);
        check("zero_seen", 32'(zero_seen), 1);
        check("zero_locked", 32'(locked), 0);
        check("zero_errcnt", 32'(err_count), 4);
        cnt = 0;
        while (!locked && cnt < 20) begin
            step(1'b0, 16'($urandom));
            good();
            cnt++;
        end
        check("gapped_lock_samples", 32'(cnt), 5);
        step(1'b1, g, 1'b1); g = nxt(g);
        step(1'b1, 16'h0000); g = nxt(g);
        check("zero2_seen",   32'(zero_seen), 1);
        check("zero2_errcnt", 32'(err_count), 1);
        check("zero2_pulse",  32'(err_pulse), 1);

        // Saturation and clear priority.
        repeat (5) good();
        repeat (20) begin
            step(1'b1, g ^ 16'h0001); g = nxt(g);
            good();
        end
        check("sat_errcnt", 32'(err_count), 32'hF);
        check("sat_locked", 32'(locked), 1);
        step(1'b1, g ^ 16'h8000, 1'b1); g = nxt(g);
        check("clr_errcnt", 32'(err_count), 0);
        check("clr_sync",   32'(sync_lost), 0);
        check("clr_zero",   32'(zero_seen), 0);
        check("clr_pulse",  32'(err_pulse), 1);

        // Reset mid-lock.
        repeat (5) begin
            step(1'b1, g ^ 16'h0100); g = nxt(g);
            good();
        end
        check("pre_rst_errcnt", 32'(err_count), 5);
        step(1'b1, g, 1'b0, 1'b1);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_errcnt", 32'(err_count), 0);
        check("midrst_pulse",  32'(err_pulse), 0);
        g = 16'hFFFF;
        repeat (4) good();
        check("rst_relock_pre", 32'(locked), 0);
        good();
        check("rst_relock", 32'(locked), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r1, r2;
            logic c, rs;
            r1 = $urandom_range(0, 99);
            r2 = $urandom_range(0, 99);
            c  = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 999) < 5);
            if (r1 >= 80) step(1'b0, 16'($urandom), c, rs);
            else begin
                if (r2 < 5)      step(1'b1, 16'($urandom), c, rs);
                else if (r2 < 7) step(1'b1, 16'h0000, c, rs);
                else             step(1'b1, g, c, rs);
                g = nxt(g);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
